// File: rtl/conv_window_ctrl_pkg.sv
// Shared types and default geometry for the conv window controller.
// Imported by the coordinate counter and the controller top.
package conv_window_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } ctrl_state_e;

    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_K      = 3;
    localparam int DEF_STRIDE = 1;
    localparam int DEF_CNT_W  = 10;

endpackage

// File: rtl/conv_window_ctrl_win_coord_cnt.sv
// Raster row/col counters with stride phase and output-map coordinates.
// Advances one pixel per adv; flags window positions, the (K-1,K-1) pixel and the last pixel.
module win_coord_cnt
    import conv_window_ctrl_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int STRIDE = DEF_STRIDE,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic             at_window,
    output logic             fill_done,
    output logic             last_pixel,
    output logic [CNT_W-1:0] out_row,
    output logic [CNT_W-1:0] out_col
);

    localparam logic [CNT_W-1:0] KM1     = CNT_W'(K - 1);
    localparam logic [CNT_W-1:0] COL_MAX = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_MAX = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] PH_MAX  = CNT_W'(STRIDE - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
    logic [CNT_W-1:0] cph_q, cph_d, rph_q, rph_d;
    logic [CNT_W-1:0] ocol_q, ocol_d, orow_q, orow_d;

    // Phase and output coordinate stay at 0 until the counter reaches K-1,
    // then step once per STRIDE positions; this replaces a divider.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        col_d  = col_q;
        row_d  = row_q;
        cph_d  = cph_q;
        rph_d  = rph_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (clr) begin
            col_d  = '0;
            row_d  = '0;
            cph_d  = '0;
            rph_d  = '0;
            ocol_d = '0;
            orow_d = '0;
        end else if (adv) begin
            col_d = (col_q == COL_MAX) ? '0 : col_q + ONE;
            if (col_d <= KM1) begin
                cph_d  = '0;
                ocol_d = '0;
            end else if (cph_q == PH_MAX) begin
                cph_d  = '0;
                ocol_d = ocol_q + ONE;
            end else begin
                cph_d = cph_q + ONE;
            end
            if (col_q == COL_MAX) begin
                row_d = (row_q == ROW_MAX) ? '0 : row_q + ONE;
                if (row_d <= KM1) begin
                    rph_d  = '0;
                    orow_d = '0;
                end else if (rph_q == PH_MAX) begin
                    rph_d  = '0;
                    orow_d = orow_q + ONE;
                end else begin
                    rph_d = rph_q + ONE;
                end
            end
        end
    end

    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            cph_q  <= '0;
            rph_q  <= '0;
            ocol_q <= '0;
            orow_q <= '0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            cph_q  <= cph_d;
            rph_q  <= rph_d;
            ocol_q <= ocol_d;
            orow_q <= orow_d;
        end
    end

    assign at_window  = (row_q >= KM1) && (col_q >= KM1) && (rph_q == '0) && (cph_q == '0);
    assign fill_done  = (row_q == KM1) && (col_q == KM1);
    assign last_pixel = (row_q == ROW_MAX) && (col_q == COL_MAX);
    assign out_row    = orow_q;
    assign out_col    = ocol_q;

endmodule

// File: rtl/conv_window_ctrl.sv
// Line-buffer sequencer for a KxK conv window: accepts the raster pixel stream,
// drives shift-enable/clear and presents each stride-aligned window to the MAC array.
module conv_window_ctrl
    import conv_window_ctrl_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K,
    parameter int STRIDE = DEF_STRIDE,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pix_vld,
    output logic             pix_rdy,
    output logic             sr_ce,
    output logic             sr_clr,
    output logic             win_vld,
    input  logic             win_rdy,
    output logic [CNT_W-1:0] win_row,
    output logic [CNT_W-1:0] win_col,
    output logic             busy,
    output logic             frame_done
);

    ctrl_state_e      state_q, state_d;
    logic             win_vld_q, win_vld_d;
    logic [CNT_W-1:0] win_row_q, win_row_d;
    logic [CNT_W-1:0] win_col_q, win_col_d;
    logic             frame_done_q, frame_done_d;

    logic             beat, win_stall, cnt_clr;
    logic             at_window, fill_done, last_pixel;
    logic [CNT_W-1:0] out_row, out_col;

    win_coord_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .STRIDE(STRIDE),
        .CNT_W (CNT_W)
    ) u_coord (
        .clk       (clk),
        .rst       (rst),
        .clr       (cnt_clr),
        .adv       (beat),
        .at_window (at_window),
        .fill_done (fill_done),
        .last_pixel(last_pixel),
        .out_row   (out_row),
        .out_col   (out_col)
    );

    always_comb begin
        state_d      = state_q;
        win_vld_d    = win_vld_q;
        win_row_d    = win_row_q;
        win_col_d    = win_col_q;
        frame_done_d = 1'b0;
        cnt_clr      = 1'b0;
        sr_clr       = 1'b0;

        // An unconsumed window back-pressures the pixel stream so it cannot be overwritten.
        win_stall = win_vld_q && !win_rdy;
        pix_rdy   = ((state_q == ST_FILL) || (state_q == ST_RUN)) && !win_stall;
        beat      = pix_vld && pix_rdy;

        if (win_vld_q && win_rdy) begin
            win_vld_d = 1'b0;
        end
        if (beat && at_window) begin
            win_vld_d = 1'b1;
            win_row_d = out_row;
            win_col_d = out_col;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sr_clr    = 1'b1;
                    cnt_clr   = 1'b1;
                    win_vld_d = 1'b0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (beat && last_pixel) begin
                    state_d = ST_DRAIN;
                end else if (beat && fill_done) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (beat && last_pixel) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!win_stall) begin
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            win_vld_q    <= 1'b0;
            win_row_q    <= '0;
            win_col_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_vld_q    <= win_vld_d;
            win_row_q    <= win_row_d;
            win_col_q    <= win_col_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sr_ce      = beat;
    assign win_vld    = win_vld_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench: a STRIDE=1 and a STRIDE=2 controller share the same stimulus and each
// window handshake is compared against a raster-order expectation of the output map.
module tb_conv_window_ctrl;

    logic clk = 1'b0;
    logic rst, start, pix_vld, win_rdy;
    logic start_nxt, pix_vld_nxt, win_rdy_nxt;
    bit   gap_en;

    logic       d0_pix_rdy, d0_sr_ce, d0_sr_clr, d0_win_vld, d0_busy, d0_frame_done;
    logic [9:0] d0_win_row, d0_win_col;
    logic       s2_pix_rdy, s2_sr_ce, s2_sr_clr, s2_win_vld, s2_busy, s2_frame_done;
    logic [9:0] s2_win_row, s2_win_col;

    conv_window_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .pix_vld(pix_vld), .pix_rdy(d0_pix_rdy),
        .sr_ce(d0_sr_ce), .sr_clr(d0_sr_clr), .win_vld(d0_win_vld), .win_rdy(win_rdy),
        .win_row(d0_win_row), .win_col(d0_win_col), .busy(d0_busy), .frame_done(d0_frame_done)
    );

    conv_window_ctrl #(.STRIDE(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .start(start), .pix_vld(pix_vld), .pix_rdy(s2_pix_rdy),
        .sr_ce(s2_sr_ce), .sr_clr(s2_sr_clr), .win_vld(s2_win_vld), .win_rdy(win_rdy),
        .win_row(s2_win_row), .win_col(s2_win_col), .busy(s2_busy), .frame_done(s2_frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Output-map widths: (28-3)/1+1 = 26 and (28-3)/2+1 = 13.
    int out_w[2] = '{26, 13};
    int exp_r[2], exp_c[2], nwin[2], beats[2], done_cnt[2];
    int win_beat0[2], win_beat1[2], last_r[2], last_c[2], last_win_cyc[2], done_cyc[2];
    bit fd_prev[2];
    int cyc = 0;

    logic [1:0] mon_vld, mon_fd, mon_busy, mon_ce;
    logic [9:0] mon_row[2], mon_col[2];
    assign mon_vld  = {s2_win_vld, d0_win_vld};
    assign mon_fd   = {s2_frame_done, d0_frame_done};
    assign mon_busy = {s2_busy, d0_busy};
    assign mon_ce   = {s2_sr_ce, d0_sr_ce};
    assign mon_row[0] = d0_win_row;
    assign mon_row[1] = s2_win_row;
    assign mon_col[0] = d0_win_col;
    assign mon_col[1] = s2_win_col;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_sb();
        for (int d = 0; d < 2; d++) begin
            exp_r[d] = 0; exp_c[d] = 0; nwin[d] = 0; beats[d] = 0; done_cnt[d] = 0;
            win_beat0[d] = -1; win_beat1[d] = -1; last_r[d] = -1; last_c[d] = -1;
            last_win_cyc[d] = 0; done_cyc[d] = 0; fd_prev[d] = 1'b0;
        end
    endtask

    // Called at the falling edge: scores handshakes that complete on the next rising edge.
    task automatic sample();
        cyc++;
        if (!rst) begin
            fd_prev[0] = 1'b0;
            fd_prev[1] = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (mon_vld[d] && win_rdy) begin
                    check($sformatf("win_row[%0d] win%0d", d, nwin[d]), mon_row[d], exp_r[d]);
                    check($sformatf("win_col[%0d] win%0d", d, nwin[d]), mon_col[d], exp_c[d]);
                    if (nwin[d] == 0) win_beat0[d] = beats[d];
                    if (nwin[d] == 1) win_beat1[d] = beats[d];
                    last_r[d] = mon_row[d];
                    last_c[d] = mon_col[d];
                    last_win_cyc[d] = cyc;
                    nwin[d]++;
                    if (exp_c[d] == out_w[d] - 1) begin
                        exp_c[d] = 0;
                        exp_r[d]++;
                    end else begin
                        exp_c[d]++;
                    end
                end
                if (fd_prev[d]) check($sformatf("frame_done_pulse[%0d]", d), mon_fd[d], 0);
                if (mon_fd[d]) begin
                    done_cnt[d]++;
                    done_cyc[d] = cyc;
                    check($sformatf("busy_at_done[%0d]", d), mon_busy[d], 0);
                end
                fd_prev[d] = mon_fd[d];
                if (mon_ce[d]) beats[d]++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        start   = start_nxt;
        win_rdy = win_rdy_nxt;
        pix_vld = gap_en ? 1'($urandom_range(0, 1)) : pix_vld_nxt;
        @(negedge clk);
        sample();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pix_rdy"}, d0_pix_rdy, 0);
        check({tag, "_sr_ce"}, d0_sr_ce, 0);
        check({tag, "_sr_clr"}, d0_sr_clr, 0);
        check({tag, "_win_vld"}, d0_win_vld, 0);
        check({tag, "_win_row"}, d0_win_row, 0);
        check({tag, "_win_col"}, d0_win_col, 0);
        check({tag, "_busy"}, d0_busy, 0);
        check({tag, "_frame_done"}, d0_frame_done, 0);
        check({tag, "_s2_win_vld"}, s2_win_vld, 0);
    endtask

    task automatic begin_frame(input string tag);
        clear_sb();
        start_nxt = 1'b1;
        tick();
        check({tag, "_sr_clr"}, d0_sr_clr, 1);
        check({tag, "_sr_clr_s2"}, s2_sr_clr, 1);
        check({tag, "_busy_at_start"}, d0_busy, 0);
        start_nxt = 1'b0;
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 8000 && beats[0] < n; i++) tick();
        if (beats[0] < n) check({tag, "_beat_timeout"}, beats[0], n);
    endtask

    task automatic finish_frame(input string tag);
        for (int i = 0; i < 8000 && !(done_cnt[0] > 0 && done_cnt[1] > 0); i++) tick();
        if (!(done_cnt[0] > 0 && done_cnt[1] > 0)) check({tag, "_done_timeout"}, 0, 1);
        check({tag, "_nwin"}, nwin[0], 676);
        check({tag, "_nwin_s2"}, nwin[1], 169);
        check({tag, "_beats"}, beats[0], 784);
        check({tag, "_first_beat"}, win_beat0[0], 59);
        check({tag, "_second_beat"}, win_beat1[0], 60);
        check({tag, "_first_beat_s2"}, win_beat0[1], 59);
        check({tag, "_second_beat_s2"}, win_beat1[1], 61);
        check({tag, "_last_row"}, last_r[0], 25);
        check({tag, "_last_col"}, last_c[0], 25);
        check({tag, "_last_row_s2"}, last_r[1], 12);
        check({tag, "_last_col_s2"}, last_c[1], 12);
        check({tag, "_done_latency"}, done_cyc[0] - last_win_cyc[0], 1);
        check({tag, "_done_count"}, done_cnt[0], 1);
    endtask

    initial begin
        logic [9:0] held_row, held_col;
        rst = 1'b0; start = 1'b0; pix_vld = 1'b1; win_rdy = 1'b1;
        start_nxt = 1'b0; pix_vld_nxt = 1'b1; win_rdy_nxt = 1'b1; gap_en = 1'b0;
        clear_sb();

        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("idle_pix_rdy", d0_pix_rdy, 0);
        check("idle_sr_ce", d0_sr_ce, 0);
        check("idle_busy", d0_busy, 0);

        begin_frame("f1");
        finish_frame("f1");
        check("f1_after_pix_rdy", d0_pix_rdy, 0);
        check("f1_after_sr_ce", d0_sr_ce, 0);

        // Stall the window handshake, then pulse a stray start mid-frame.
        begin_frame("f2");
        for (int i = 0; i < 4000 && nwin[0] < 100; i++) tick();
        win_rdy_nxt = 1'b0;
        tick();
        for (int i = 0; i < 10 && !d0_win_vld; i++) tick();
        held_row = d0_win_row;
        held_col = d0_win_col;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d_win_vld", i), d0_win_vld, 1);
            check($sformatf("stall%0d_pix_rdy", i), d0_pix_rdy, 0);
            check($sformatf("stall%0d_sr_ce", i), d0_sr_ce, 0);
            check($sformatf("stall%0d_row", i), d0_win_row, held_row);
            check($sformatf("stall%0d_col", i), d0_win_col, held_col);
            if (i == 4) win_rdy_nxt = 1'b1;
            tick();
        end
        wait_beats("f2", 500);
        start_nxt = 1'b1;
        tick();
        check("f2_stray_start_sr_clr", d0_sr_clr, 0);
        check("f2_stray_start_busy", d0_busy, 1);
        start_nxt = 1'b0;
        finish_frame("f2");

        // Asynchronous reset in the middle of RUN abandons the frame.
        begin_frame("f3");
        wait_beats("f3", 300);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        @(posedge clk);
        #1 rst = 1'b1;
        begin_frame("f4");
        finish_frame("f4");

        // Random upstream gaps must not change the window sequence.
        gap_en = 1'b1;
        begin_frame("f5");
        finish_frame("f5");
        gap_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
